// File: rtl/fpu_div_seq_pkg.sv
// Shared types and defaults for the FPU division sequencer.
// Optional early-exit feature is controlled by macro FPU_DIV_EARLY_EXIT_EN
// (used in fpu_division_sequencer.sv).
package fpu_div_seq_pkg;

  // Quotient bits per divide: 24 mantissa bits + guard + round.
  localparam int DEFAULT_DIV_ITERATIONS = 26;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ITERATE = 2'd1,
    DONE    = 2'd2
  } div_state;

endpackage

// File: rtl/fpu_iteration_counter.sv
// Down-counter for the radix-2 divide loop: clear / load / decrement / hold.
// Priority is clear > load > decrement. zero flags a count of 0.
module fpu_iteration_counter #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         zero
);

  logic [W-1:0] count_d;
  logic [W-1:0] count_q;

  // Next-count selection; a decrement at zero holds rather than wrapping.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  // Counter register, cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign zero  = (count_q == '0);

endmodule

// File: rtl/fpu_division_sequencer.sv
// Stall/sequence controller for the multi-cycle, non-pipelined FPU divide.
// Holds stage-1/stage-2 while a divide iterates, drives the datapath iteration
// index and mode, and releases the pipe with a one-cycle done pulse.
// Optional macro FPU_DIV_EARLY_EXIT_EN adds the remainder_zero input, which
// terminates a divide early once the partial remainder is exactly zero.
module fpu_division_sequencer
  import fpu_div_seq_pkg::*;
#(
  parameter  int ITERATIONS = DEFAULT_DIV_ITERATIONS,
  localparam int COUNT_W    = $clog2(ITERATIONS)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               division_op,
  input  logic               output_stall,
  input  logic               flush,
`ifdef FPU_DIV_EARLY_EXIT_EN
  input  logic               remainder_zero,
`endif
  output logic               stall,
  output logic               division_mode,
  output logic [COUNT_W-1:0] iteration_index,
  output logic               busy,
  output logic               done
);

  localparam logic [COUNT_W-1:0] LAST_COUNT = COUNT_W'(ITERATIONS - 1);

  // Handshake: stall is a level "not ready" toward stage-1/stage-2. While it
  // is high those registers hold their contents (including division_op); a
  // register update happens only on a rising edge where stall was low.

  div_state           state_d;
  div_state           state_q;
  logic               cnt_clear;
  logic               cnt_load;
  logic               cnt_dec;
  logic [COUNT_W-1:0] cnt_value;
  logic               cnt_zero;
  logic               early_exit;
  logic               internal_stall;

`ifdef FPU_DIV_EARLY_EXIT_EN
  assign early_exit = remainder_zero;
`else
  assign early_exit = 1'b0;
`endif

  fpu_iteration_counter #(
    .W (COUNT_W)
  ) u_counter (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (cnt_clear),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (LAST_COUNT),
    .count    (cnt_value),
    .zero     (cnt_zero)
  );

  // Next-state and counter control; flush outranks everything, and
  // output_stall freezes IDLE and ITERATE but never DONE.
  always_comb begin
    state_d   = state_q;
    cnt_clear = 1'b0;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    if (flush) begin
      state_d   = IDLE;
      cnt_clear = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (division_op && !output_stall) begin
            state_d  = ITERATE;
            cnt_load = 1'b1;
          end
        end
        ITERATE: begin
          if (!output_stall) begin
            if (cnt_zero || early_exit) begin
              state_d   = DONE;
              cnt_clear = 1'b1;
            end else begin
              cnt_dec = 1'b1;
            end
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d   = IDLE;
          cnt_clear = 1'b1;
        end
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Output decode. The IDLE stall term covers the detect cycle so the divide
  // is held before the first iteration; it is masked while reset is asserted.
  always_comb begin
    internal_stall  = 1'b0;
    division_mode   = 1'b0;
    busy            = 1'b0;
    done            = 1'b0;
    iteration_index = '0;
    case (state_q)
      IDLE: begin
        internal_stall = division_op && !flush;
      end
      ITERATE: begin
        internal_stall  = 1'b1;
        division_mode   = 1'b1;
        busy            = 1'b1;
        iteration_index = LAST_COUNT - cnt_value;
      end
      DONE: begin
        busy = 1'b1;
        done = !flush;
      end
      default: begin
        internal_stall = 1'b0;
      end
    endcase
    stall = output_stall || (internal_stall && reset_n);
  end

endmodule

// File: tb/tb_fpu_division_sequencer.sv
// Directed bench for fpu_division_sequencer (ITERATIONS=26).
// Cycle 0 of each window is the first cycle division_op=1.
module tb_fpu_division_sequencer;

  localparam int ITER = 26;
  localparam int CW   = $clog2(ITER);
  localparam int MAXC = 100;

  logic          clk;
  logic          reset_n;
  logic          division_op;
  logic          output_stall;
  logic          flush;
  logic          remainder_zero;
  logic          stall;
  logic          division_mode;
  logic [CW-1:0] iteration_index;
  logic          busy;
  logic          done;

  int n_vec;
  int n_bad;

  int stall_log [MAXC];
  int mode_log  [MAXC];
  int idx_log   [MAXC];
  int busy_log  [MAXC];
  int done_log  [MAXC];

  typedef struct {
    string name;
    int    op_len;
    int    os_from;
    int    os_to;
    int    fl_at;
    int    rz_at;
    int    exp_done_cycle;
    int    exp_done_cnt;
    int    exp_stall_cnt;
    int    exp_mode_cnt;
    int    chk_c;
    int    exp_idx;
    int    exp_busy;
  } vec_t;

  vec_t vecs[$];

  fpu_division_sequencer #(
    .ITERATIONS (ITER)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .division_op     (division_op),
    .output_stall    (output_stall),
    .flush           (flush),
`ifdef FPU_DIV_EARLY_EXIT_EN
    .remainder_zero  (remainder_zero),
`endif
    .stall           (stall),
    .division_mode   (division_mode),
    .iteration_index (iteration_index),
    .busy            (busy),
    .done            (done)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard compare
  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Driver: entered at posedge+1; drives one window of ncyc cycles and logs
  // the outputs sampled at each negedge.
  task automatic run_window(input int op_len, input int os_from, input int os_to,
                            input int fl_at, input int rz_at, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      division_op    = (c < op_len);
      output_stall   = (c >= os_from) && (c <= os_to);
      flush          = (c == fl_at);
      remainder_zero = (c == rz_at);
      @(negedge clk);
      stall_log[c] = int'(stall);
      mode_log[c]  = int'(division_mode);
      idx_log[c]   = int'(iteration_index);
      busy_log[c]  = int'(busy);
      done_log[c]  = int'(done);
      @(posedge clk);
      #1;
    end
    division_op    = 1'b0;
    output_stall   = 1'b0;
    flush          = 1'b0;
    remainder_zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int ncyc;
    int d_first;
    int d_cnt;
    int s_cnt;
    int m_cnt;
    int seen;
    int errs;

    n_vec = 0;
    n_bad = 0;

    vecs.push_back(vec_t'{"plain",        28, -1, -2, -1, -1, 27, 1, 27, 26, 26, 25, 1});
    vecs.push_back(vec_t'{"os_idx10",     31, 11, 13, -1, -1, 30, 1, 30, 29, 14, 10, 1});
    vecs.push_back(vec_t'{"flush_idx5",    7, -1, -2,  6, -1, -1, 0,  7,  6,  7,  0, 0});
    vecs.push_back(vec_t'{"os_in_idle",   30,  0,  1, -1, -1, 29, 1, 29, 26,  3,  0, 1});
    vecs.push_back(vec_t'{"os_in_done",   28, 27, 27, -1, -1, 27, 1, 28, 26, 28,  0, 0});
    vecs.push_back(vec_t'{"flush_done",   28, -1, -2, 27, -1, -1, 0, 27, 26, 28,  0, 0});
    vecs.push_back(vec_t'{"flush_idle",    1, -1, -2,  0, -1, -1, 0,  0,  0,  1,  0, 0});
    vecs.push_back(vec_t'{"flush_vs_os",   8,  5,  9,  7, -1, -1, 0, 10,  7,  7,  4, 1});
`ifdef FPU_DIV_EARLY_EXIT_EN
    vecs.push_back(vec_t'{"early_exit",   10, -1, -2, -1,  8,  9, 1,  9,  8,  8,  7, 1});
`else
    vecs.push_back(vec_t'{"no_early_exit",10, -1, -2, -1,  8, 27, 1, 27, 26,  8,  7, 1});
`endif

    // Reset block: outputs quiet under reset even with division_op=1
    reset_n        = 1'b0;
    division_op    = 1'b1;
    output_stall   = 1'b0;
    flush          = 1'b0;
    remainder_zero = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_stall", int'(stall), 0);
    chk("reset_busy",  int'(busy), 0);
    chk("reset_done",  int'(done), 0);
    chk("reset_mode",  int'(division_mode), 0);
    chk("reset_index", int'(iteration_index), 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("release_stall", int'(stall), 1);
    chk("release_busy",  int'(busy), 0);
    @(posedge clk);
    #1;
    division_op = 1'b0;
    seen = 0;
    for (int i = 0; i < 40 && seen == 0; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk("release_divide_done", seen, 1);
    repeat (2) @(posedge clk);
    #1;

    // Table-driven vectors
    ncyc = 40;
    foreach (vecs[v]) begin
      run_window(vecs[v].op_len, vecs[v].os_from, vecs[v].os_to,
                 vecs[v].fl_at, vecs[v].rz_at, ncyc);
      d_first = -1;
      d_cnt   = 0;
      s_cnt   = 0;
      m_cnt   = 0;
      for (int c = 0; c < ncyc; c++) begin
        if (done_log[c] != 0) begin
          if (d_first < 0) d_first = c;
          d_cnt++;
        end
        s_cnt += stall_log[c];
        m_cnt += mode_log[c];
      end
      chk({vecs[v].name, "_done_cycle"}, d_first, vecs[v].exp_done_cycle);
      chk({vecs[v].name, "_done_cnt"},   d_cnt,   vecs[v].exp_done_cnt);
      chk({vecs[v].name, "_stall_cnt"},  s_cnt,   vecs[v].exp_stall_cnt);
      chk({vecs[v].name, "_mode_cnt"},   m_cnt,   vecs[v].exp_mode_cnt);
      chk({vecs[v].name, "_idx"},  idx_log[vecs[v].chk_c],  vecs[v].exp_idx);
      chk({vecs[v].name, "_busy"}, busy_log[vecs[v].chk_c], vecs[v].exp_busy);
    end

    // Single divide, cycle by cycle
    run_window(28, -1, -2, -1, -1, 30);
    errs = 0;
    for (int c = 1; c <= 26; c++) begin
      if (idx_log[c] != c - 1) errs++;
      if (mode_log[c] != 1) errs++;
      if (stall_log[c] != 1) errs++;
    end
    chk("single_iter_seq_errs", errs, 0);
    chk("single_stall_c0",  stall_log[0], 1);
    chk("single_mode_c0",   mode_log[0], 0);
    chk("single_stall_c27", stall_log[27], 0);
    chk("single_done_c27",  done_log[27], 1);
    chk("single_mode_c27",  mode_log[27], 0);
    chk("single_busy_c28",  busy_log[28], 0);

    // Back-to-back divides, no bubble
    run_window(56, -1, -2, -1, -1, 60);
    s_cnt = 0;
    d_cnt = 0;
    for (int c = 28; c <= 54; c++) s_cnt += stall_log[c];
    for (int c = 0; c < 60; c++) d_cnt += done_log[c];
    chk("b2b_done_c27",      done_log[27], 1);
    chk("b2b_done_c55",      done_log[55], 1);
    chk("b2b_done_cnt",      d_cnt, 2);
    chk("b2b_stall_28_54",   s_cnt, 27);
    chk("b2b_stall_c55",     stall_log[55], 0);
    chk("b2b_idx_c29",       idx_log[29], 0);

    // Mid-operation asynchronous reset
    division_op = 1'b1;
    repeat (6) @(posedge clk);
    #2;
    chk("midop_busy_before", int'(busy), 1);
    reset_n = 1'b0;
    #1;
    chk("midop_reset_busy",  int'(busy), 0);
    chk("midop_reset_index", int'(iteration_index), 0);
    chk("midop_reset_stall", int'(stall), 0);
    division_op = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("midop_after_busy", int'(busy), 0);
    chk("midop_after_mode", int'(division_mode), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
